// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: ALU control encoding, the prediction record
// carried down the pipe, and the control-flow opcode set used by both the
// fetch predictor and the execute-side resolver.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [4:0] {
        ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI, AUIPC,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
    } alu_ctrl_e;

    // Prediction made at fetch, travelling with the instruction through D and E
    typedef struct packed {
        logic            vld;
        logic            ptaken;
        logic [XLEN-1:0] ptarget;
    } pred_info_t;

    // Operations that change control flow and therefore train the predictor
    function automatic logic is_ctrl_op(input alu_ctrl_e op);
        return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of fetch-side prediction inputs, pipeline controls, E-stage
// resolution inputs and the redirect / training / statistics outputs.
interface branch_resolve_unit_if
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [XLEN-1:0]  pcF_i;
    logic             predF_taken_i;
    logic [XLEN-1:0]  predF_target_i;
    logic             stallD_i;
    logic             stallE_i;
    logic             flushD_i;
    logic             flushE_i;
    alu_ctrl_e        opE_i;
    logic [XLEN-1:0]  pcE_i;
    logic             takenE_i;
    logic [XLEN-1:0]  targetE_i;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             upd_en_o;
    logic [XLEN-1:0]  upd_pc_o;
    logic             upd_taken_o;
    logic [XLEN-1:0]  upd_target_o;
    logic [CNT_W-1:0] br_cnt_o;
    logic [CNT_W-1:0] mis_cnt_o;

    modport master (
        output pcF_i, predF_taken_i, predF_target_i, stallD_i, stallE_i,
               flushD_i, flushE_i, opE_i, pcE_i, takenE_i, targetE_i,
        input  redirect_o, redirect_pc_o, upd_en_o, upd_pc_o, upd_taken_o,
               upd_target_o, br_cnt_o, mis_cnt_o
    );

    modport slave (
        input  pcF_i, predF_taken_i, predF_target_i, stallD_i, stallE_i,
               flushD_i, flushE_i, opE_i, pcE_i, takenE_i, targetE_i,
        output redirect_o, redirect_pc_o, upd_en_o, upd_pc_o, upd_taken_o,
               upd_target_o, br_cnt_o, mis_cnt_o
    );

endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cntReg;

    // Count events, holding at the maximum value once reached
    always_ff @(posedge clk_i) begin
        if (rst) begin
            cntReg <= '0;
        end else if (inc_i && (cntReg != '1)) begin
            cntReg <= cntReg + CNT_W'(1);
        end
    end

    assign cnt_o = cntReg;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolver: carries fetch predictions through D and E,
// checks them against the resolved outcome, raises redirect requests,
// drives predictor training and keeps branch / mispredict statistics.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                   clk_i,
    input logic                   rstn_i,   // synchronous, active-high
    branch_resolve_unit_if.slave  bus
);

    pred_info_t       dReg;
    pred_info_t       eReg;
    logic             isBr;
    logic             active;
    logic             mis;
    logic             updEn;
    logic [XLEN-1:0]  seqPc;
    logic [CNT_W-1:0] brCnt;
    logic [CNT_W-1:0] misCnt;
    logic             unusedPcF;

    // The fetch PC is part of the predictor-facing bundle but the prediction
    // record does not need it; E supplies its own PC.
    assign unusedPcF = ^bus.pcF_i;

    // Reset gates activity so nothing leaks out during the reset cycle
    assign isBr   = is_ctrl_op(bus.opE_i);
    assign active = eReg.vld & ~bus.stallE_i & ~bus.flushE_i & ~rstn_i;
    assign updEn  = active & isBr;
    assign seqPc  = bus.pcE_i + XLEN'(INSTR_BYTES);

    // Mispredict detection: wrong direction, wrong target, or a stale BTB hit
    // on a non-control instruction
    always_comb begin
        mis = 1'b0;
        if (active) begin
            if (isBr) begin
                mis = (eReg.ptaken != bus.takenE_i) |
                      (eReg.ptaken & bus.takenE_i & (eReg.ptarget != bus.targetE_i));
            end else begin
                mis = eReg.ptaken;
            end
        end
    end

    assign bus.redirect_o    = mis;
    assign bus.redirect_pc_o = !mis ? '0 : ((bus.takenE_i & isBr) ? bus.targetE_i : seqPc);
    assign bus.upd_en_o      = updEn;
    assign bus.upd_pc_o      = updEn ? bus.pcE_i     : '0;
    assign bus.upd_taken_o   = updEn & bus.takenE_i;
    assign bus.upd_target_o  = updEn ? bus.targetE_i : '0;

    // F->D prediction register; a redirect squashes the wrong-path entry
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            dReg <= '0;
        end else if (bus.flushD_i || mis) begin
            dReg <= '0;
        end else if (!bus.stallD_i) begin
            dReg.vld     <= 1'b1;
            dReg.ptaken  <= bus.predF_taken_i;
            dReg.ptarget <= bus.predF_target_i;
        end
    end

    // D->E prediction register, same reset / squash / hold priority
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            eReg <= '0;
        end else if (bus.flushE_i || mis) begin
            eReg <= '0;
        end else if (!bus.stallE_i) begin
            eReg <= dReg;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) uBrCnt (
        .clk_i (clk_i),
        .rst   (rstn_i),
        .inc_i (updEn),
        .cnt_o (brCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) uMisCnt (
        .clk_i (clk_i),
        .rst   (rstn_i),
        .inc_i (mis),
        .cnt_o (misCnt)
    );

    // Statistics read as zero while reset is held
    assign bus.br_cnt_o  = rstn_i ? '0 : brCnt;
    assign bus.mis_cnt_o = rstn_i ? '0 : misCnt;

endmodule
